axis_frame_conditioner: RTL and testbench

- Sits directly upstream of the barrel distortion corrector; it conditions a camera/DMA AXI4-Stream into a strict WIDTH×HEIGHT raster.
- Guarantees the corrector's assumptions:
  - tuser only on pixel (0,0);
  - tlast on every line end (x==WIDTH-1);
  - exactly WIDTH pixels per line and HEIGHT lines per frame.
- Short lines and frames are padded with FILL_VALUE; long lines and extra lines are discarded; each fault is reported as a 1-cycle pulse.

---
 rtl/barrel_video_pkg.sv | 16 +
 rtl/axis_frame_conditioner_if.sv | 13 +
 rtl/axis_reg_slice.sv | 27 ++
 rtl/axis_frame_conditioner.sv | 162 ++++++++++++++++
 tb/tb_axis_frame_conditioner.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_video_pkg.sv
// Shared video-pipeline types and default raster geometry for the barrel
// distortion chain (conditioner and corrector).
package barrel_video_pkg;
  localparam int DEF_WIDTH       = 1920;
  localparam int DEF_HEIGHT      = 1080;
  localparam int DEF_DATA_WIDTH  = 24;
  localparam int DEF_COORD_WIDTH = 16;

  typedef enum logic [2:0] {
    WAIT_SOF,
    PASS,
    PAD_LINE,
    DROP_LINE,
    PAD_FRAME
  } cond_state_t;
endpackage

// File: rtl/axis_frame_conditioner_if.sv
// AXI4-Stream video bus: pixel, valid/ready, end-of-line and start-of-frame.
interface axis_frame_conditioner_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;
  logic                  tready;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_reg_slice.sv
// One-deep output register slice. A new word is loaded whenever the slot is
// empty or being drained this cycle; the word is held while stalled.
module axis_reg_slice #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         adv,
  output logic         valid,
  output logic [W-1:0] dout
);
  assign adv = !valid || ready;

  // Output register: refill on advance, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (adv) begin
      valid <= load;
      if (load) dout <= din;
    end
  end
endmodule

// File: rtl/axis_frame_conditioner.sv
// Forces an incoming AXI4-Stream into a strict WIDTH x HEIGHT raster:
// pads short lines/frames with FILL_VALUE, drops overlong lines and stray
// beats, and flags each fault with a one-cycle pulse.
module axis_frame_conditioner
  import barrel_video_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COORD_WIDTH = DEF_COORD_WIDTH,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  axis_frame_conditioner_if.slave  s_axis,
  axis_frame_conditioner_if.master m_axis,
  output logic err_short_line,
  output logic err_long_line,
  output logic err_early_sof,
  output logic err_orphan,
  output logic frame_done
);
  localparam logic [COORD_WIDTH-1:0] XMAX = COORD_WIDTH'(WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] YMAX = COORD_WIDTH'(HEIGHT - 1);

  cond_state_t state, nx_state;
  logic [COORD_WIDTH-1:0] x, y;
  logic at_eol, at_eof, adv, out_valid, eof_r;
  logic tready_c, accept, fwd, emit, step;
  logic [DATA_WIDTH-1:0] e_data;
  logic e_user, e_short, e_long, e_sof, e_orph;
  logic [DATA_WIDTH+1:0] slice_d, slice_q;

  // x/y always name the next pixel to be emitted
  assign at_eol = (x == XMAX);
  assign at_eof = at_eol && (y == YMAX);

  // Ready, emit and next-state decode for the current cycle
  always_comb begin
    tready_c = 1'b0;
    fwd      = 1'b0;
    emit     = 1'b0;
    step     = 1'b0;
    e_data   = FILL_VALUE;
    e_user   = 1'b0;
    e_short  = 1'b0;
    e_long   = 1'b0;
    e_sof    = 1'b0;
    e_orph   = 1'b0;
    nx_state = state;
    unique case (state)
      WAIT_SOF:  tready_c = adv;
      PASS:      tready_c = adv && !s_axis.tuser;  // mid-frame SOF is left pending
      DROP_LINE: tready_c = !s_axis.tuser;
      default:   tready_c = 1'b0;
    endcase
    if (rst) tready_c = 1'b0;
    accept = s_axis.tvalid && tready_c;

    case (state)
      WAIT_SOF: if (accept) begin
        if (s_axis.tuser) fwd = 1'b1;
        else              e_orph = 1'b1;
      end
      PASS: begin
        if (s_axis.tvalid && s_axis.tuser && adv) begin
          e_sof    = 1'b1;
          nx_state = PAD_FRAME;
        end else if (accept) begin
          fwd = 1'b1;
        end
      end
      PAD_LINE: if (adv) begin
        emit = 1'b1;
        step = 1'b1;
        if (at_eol) nx_state = at_eof ? WAIT_SOF : PASS;
      end
      DROP_LINE: begin
        // y==0 here means the dropped tail belonged to the frame's last line
        if (s_axis.tvalid && s_axis.tuser) begin
          e_sof    = 1'b1;
          nx_state = (y == '0) ? WAIT_SOF : PAD_FRAME;
        end else if (accept && s_axis.tlast) begin
          nx_state = (y == '0) ? WAIT_SOF : PASS;
        end
      end
      PAD_FRAME: if (adv) begin
        emit = 1'b1;
        step = 1'b1;
        if (at_eof) nx_state = WAIT_SOF;
      end
      default: ;
    endcase

    // A forwarded beat is judged against the line geometry at its x
    if (fwd) begin
      emit   = 1'b1;
      step   = 1'b1;
      e_data = s_axis.tdata;
      e_user = (state == WAIT_SOF);
      if (s_axis.tlast && !at_eol) begin
        e_short  = 1'b1;
        nx_state = PAD_LINE;
      end else if (!s_axis.tlast && at_eol) begin
        e_long   = 1'b1;
        nx_state = DROP_LINE;
      end else begin
        nx_state = at_eof ? WAIT_SOF : PASS;
      end
    end
  end

  assign s_axis.tready = tready_c;
  assign slice_d       = {at_eol, e_user, e_data};

  axis_reg_slice #(.W(DATA_WIDTH + 2)) u_slice (
    .clk   (clk),
    .rst   (rst),
    .load  (emit),
    .din   (slice_d),
    .ready (m_axis.tready),
    .adv   (adv),
    .valid (out_valid),
    .dout  (slice_q)
  );

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = slice_q[DATA_WIDTH-1:0];
  assign m_axis.tuser  = slice_q[DATA_WIDTH];
  assign m_axis.tlast  = slice_q[DATA_WIDTH+1];

  // FSM state, raster counters and registered fault/frame pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_SOF;
      x              <= '0;
      y              <= '0;
      eof_r          <= 1'b0;
      err_short_line <= 1'b0;
      err_long_line  <= 1'b0;
      err_early_sof  <= 1'b0;
      err_orphan     <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= nx_state;
      err_short_line <= e_short;
      err_long_line  <= e_long;
      err_early_sof  <= e_sof;
      err_orphan     <= e_orph;
      if (step) begin
        if (at_eol) begin
          x <= '0;
          y <= at_eof ? '0 : y + COORD_WIDTH'(1);
        end else begin
          x <= x + COORD_WIDTH'(1);
        end
      end
      if (adv) eof_r <= emit && at_eof;
      frame_done <= out_valid && m_axis.tready && eof_r;
    end
  end
endmodule

// File: tb/tb_axis_frame_conditioner.sv
// Scenario table drives whole frames through the conditioner; a scoreboard
// queue holds the expected output beats and fault pulse counts are compared
// per scenario. A hand-written reset sequence follows the table.
module tb_axis_frame_conditioner;
  localparam logic [23:0] FILL = 24'hABCDEF;

  typedef struct packed { logic [23:0] d; logic l; logic u; } beat_t;
  typedef struct {
    int kind; int bp;
    int e_short; int e_long; int e_sof; int e_orph; int e_done; int e_beats;
  } scen_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_short_line, err_long_line, err_early_sof, err_orphan, frame_done;

  axis_frame_conditioner_if #(.DATA_WIDTH(24)) s_if ();
  axis_frame_conditioner_if #(.DATA_WIDTH(24)) m_if ();

  axis_frame_conditioner #(
    .WIDTH(8), .HEIGHT(4), .DATA_WIDTH(24), .COORD_WIDTH(16), .FILL_VALUE(FILL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .err_short_line (err_short_line),
    .err_long_line  (err_long_line),
    .err_early_sof  (err_early_sof),
    .err_orphan     (err_orphan),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_short = 0, n_long = 0, n_sof = 0, n_orph = 0, n_done = 0, n_beats = 0;
  logic bp_on = 1'b0;
  beat_t exp_q[$];
  beat_t in_q[$];
  scen_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [23:0] pix(input int t, input int yy, input int xx);
    return {8'(t), 8'(yy), 8'(xx)};
  endfunction

  task automatic add_in(input logic [23:0] d, input logic l, input logic u);
    in_q.push_back('{d: d, l: l, u: u});
  endtask

  task automatic add_exp(input logic [23:0] d, input logic l, input logic u);
    exp_q.push_back('{d: d, l: l, u: u});
  endtask

  task automatic clean_frame(input int t);
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++) begin
        add_in(pix(t, yy, xx), xx == 7, yy == 0 && xx == 0);
        add_exp(pix(t, yy, xx), xx == 7, yy == 0 && xx == 0);
      end
  endtask

  // Called at a negedge; holds the beat until s_tready is seen before a posedge
  task automatic send(input beat_t b);
    int n = 0;
    logic done = 1'b0;
    s_if.tdata  = b.d;
    s_if.tlast  = b.l;
    s_if.tuser  = b.u;
    s_if.tvalid = 1'b1;
    while (!done) begin
      #4;
      done = s_if.tready;
      @(negedge clk);
      n++;
      if (!done && n > 500) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat %h not accepted in 500 cycles", b.d);
        done = 1'b1;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic build(input int kind, input int t);
    in_q.delete();
    case (kind)
      0, 4: clean_frame(t);
      1: for (int yy = 0; yy < 4; yy++) begin
        int len = (yy == 1) ? 5 : 8;
        for (int xx = 0; xx < len; xx++) begin
          add_in(pix(t, yy, xx), xx == len - 1, yy == 0 && xx == 0);
          add_exp(pix(t, yy, xx), xx == 7, yy == 0 && xx == 0);
        end
        if (yy == 1) for (int xx = 5; xx < 8; xx++) add_exp(FILL, xx == 7, 1'b0);
      end
      2: for (int yy = 0; yy < 4; yy++) begin
        int len = (yy == 0) ? 11 : 8;
        for (int xx = 0; xx < len; xx++) begin
          add_in(pix(t, yy, xx), xx == len - 1, yy == 0 && xx == 0);
          if (xx < 8) add_exp(pix(t, yy, xx), xx == 7, yy == 0 && xx == 0);
        end
      end
      3: begin
        for (int i = 0; i < 20; i++) begin
          add_in(pix(t, i / 8, i % 8), (i % 8) == 7, i == 0);
          add_exp(pix(t, i / 8, i % 8), (i % 8) == 7, i == 0);
        end
        for (int i = 20; i < 32; i++) add_exp(FILL, (i % 8) == 7, 1'b0);
        clean_frame(t + 1);
      end
      5: for (int xx = 0; xx < 3; xx++) add_in(pix(t, 0, xx), 1'b0, 1'b0);
      default: for (int yy = 0; yy < 4; yy++) begin
        int len = (yy == 3) ? 10 : 8;
        for (int xx = 0; xx < len; xx++) begin
          add_in(pix(t, yy, xx), xx == len - 1, yy == 0 && xx == 0);
          if (xx < 8) add_exp(pix(t, yy, xx), xx == 7, yy == 0 && xx == 0);
        end
      end
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int b_short, b_long, b_sof, b_orph, b_done, b_beats;
    beat_t hold, got, e;
    logic stalled;
    //          kind bp short long sof orph done beats
    tbl[0] = '{0, 0, 0, 0, 0, 0, 1, 32};  // clean
    tbl[1] = '{1, 0, 1, 0, 0, 0, 1, 32};  // short line 1
    tbl[2] = '{2, 0, 0, 1, 0, 0, 1, 32};  // long line 0
    tbl[3] = '{3, 0, 0, 0, 1, 0, 2, 64};  // early SOF after 20 beats
    tbl[4] = '{4, 1, 0, 0, 0, 0, 1, 32};  // clean under backpressure
    tbl[5] = '{5, 0, 0, 0, 0, 3, 0, 0};   // orphans
    tbl[6] = '{6, 0, 0, 1, 0, 0, 1, 32};  // long last line of frame

    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    stalled = 1'b0;
    hold = '0;
    repeat (3) @(negedge clk);
    s_if.tvalid = 1'b1;
    #1;
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    chk("rst_errs", 32'({err_short_line, err_long_line, err_early_sof, err_orphan, frame_done}), 32'd0);
    chk("rst_m_bus", 32'({m_if.tdata, m_if.tlast, m_if.tuser}), 32'd0);
    s_if.tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (bp_on) m_if.tready = 1'($urandom_range(0, 1));
        #4;
        if (rst) stalled = 1'b0;
        else begin
          got = '{d: m_if.tdata, l: m_if.tlast, u: m_if.tuser};
          if (stalled) begin
            checks++;
            if (!m_if.tvalid || got != hold) begin
              errors++;
              $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_if.tvalid, got, hold);
            end
          end
          stalled = m_if.tvalid && !m_if.tready;
          hold = got;
          if (m_if.tvalid && m_if.tready) begin
            checks++;
            n_beats++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL unexpected_beat: got d=%h l=%b u=%b expected none", got.d, got.l, got.u);
            end else begin
              e = exp_q.pop_front();
              if (got != e) begin
                errors++;
                $display("FAIL beat: got d=%h l=%b u=%b expected d=%h l=%b u=%b",
                         got.d, got.l, got.u, e.d, e.l, e.u);
              end
            end
          end
          n_short += int'(err_short_line);
          n_long  += int'(err_long_line);
          n_sof   += int'(err_early_sof);
          n_orph  += int'(err_orphan);
          n_done  += int'(frame_done);
        end
      end
    join_none

    for (int s = 0; s < 7; s++) begin
      b_short = n_short; b_long = n_long; b_sof = n_sof;
      b_orph = n_orph; b_done = n_done; b_beats = n_beats;
      build(tbl[s].kind, s * 2 + 1);
      bp_on = tbl[s].bp[0];
      for (int i = 0; i < in_q.size(); i++) send(in_q[i]);
      drain();
      bp_on = 1'b0;
      m_if.tready = 1'b1;
      $display("scenario %0d", s);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("beats", 32'(n_beats - b_beats), 32'(tbl[s].e_beats));
      chk("err_short_line", 32'(n_short - b_short), 32'(tbl[s].e_short));
      chk("err_long_line", 32'(n_long - b_long), 32'(tbl[s].e_long));
      chk("err_early_sof", 32'(n_sof - b_sof), 32'(tbl[s].e_sof));
      chk("err_orphan", 32'(n_orph - b_orph), 32'(tbl[s].e_orph));
      chk("frame_done", 32'(n_done - b_done), 32'(tbl[s].e_done));
    end

    // Reset mid-line with a stalled beat in the output register
    exp_q.delete();
    add_exp(pix(20, 0, 0), 1'b0, 1'b1);
    send('{d: pix(20, 0, 0), l: 1'b0, u: 1'b1});
    send('{d: pix(20, 0, 1), l: 1'b0, u: 1'b0});
    m_if.tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_before_rst", 32'(m_if.tvalid), 32'd1);
    rst = 1'b1;
    s_if.tdata = pix(20, 0, 2); s_if.tlast = 1'b0; s_if.tuser = 1'b0; s_if.tvalid = 1'b1;
    #4;
    chk("s_tready_in_rst", 32'(s_if.tready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    #1;
    chk("m_tvalid_after_rst", 32'(m_if.tvalid), 32'd0);
    chk("exp_after_rst", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    b_done = n_done; b_beats = n_beats; b_orph = n_orph;
    b_short = n_short; b_long = n_long; b_sof = n_sof;
    build(0, 30);
    for (int i = 0; i < in_q.size(); i++) send(in_q[i]);
    drain();
    chk("post_rst_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("post_rst_beats", 32'(n_beats - b_beats), 32'd32);
    chk("post_rst_done", 32'(n_done - b_done), 32'd1);
    chk("post_rst_errs", 32'((n_orph - b_orph) + (n_short - b_short) + (n_long - b_long) + (n_sof - b_sof)), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
